// File: rtl/fifo_unpacker.sv
// Width-down converter on the read side of a show-ahead FIFO. It pops one IN_WIDTH
// word and streams it out as RATIO slices on a valid/ready interface with no bubbles.
module fifo_unpacker #(
    parameter int IN_WIDTH  = 16,
    parameter int RATIO     = 2,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_flush,
    input  logic [IN_WIDTH-1:0]       i_fifo_rdata,
    input  logic                      i_fifo_not_empty,
    output logic                      o_fifo_pop,
    output logic [IN_WIDTH/RATIO-1:0] o_data,
    output logic                      o_valid,
    input  logic                      i_ready,
    output logic                      o_last,
    output logic                      o_busy
);

    localparam int OUT_WIDTH = IN_WIDTH / RATIO;
    localparam int CNT_W     = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RATIO - 1);

    typedef enum logic {
        EMPTY = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t              state;
    logic [IN_WIDTH-1:0] hold;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    slice_idx;
    logic                full;
    logic                accept;

    assign full    = (state == HOLD);
    assign o_valid = full;
    assign o_busy  = full;
    assign o_last  = full && (cnt == LAST_CNT);
    assign accept  = o_valid && i_ready;

    // Refill in the same cycle the last slice leaves, so words stream back to back.
    assign o_fifo_pop = !i_flush && i_fifo_not_empty && (!full || (accept && o_last));

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge values of its neighbours regardless of statement order.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= EMPTY;
            // NOTE: hold is datapath, but it is cleared so o_data reads zero after
            // reset and flush instead of exposing a stale word.
            hold  <= '0;
            cnt   <= '0;
        end else if (i_flush) begin
            state <= EMPTY;
            hold  <= '0;
            cnt   <= '0;
        end else if (o_fifo_pop) begin
            state <= HOLD;
            hold  <= i_fifo_rdata;
            cnt   <= '0;
        end else if (accept) begin
            if (o_last) begin
                state <= EMPTY;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign slice_idx = MSB_FIRST ? (LAST_CNT - cnt) : cnt;

    // NOTE: o_data gets a default before the loop; without it the mux would infer a latch.
    always_comb begin
        o_data = '0;
        for (int i = 0; i < RATIO; i++) begin
            if (slice_idx == CNT_W'(i)) begin
                o_data = hold[i*OUT_WIDTH +: OUT_WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_fifo_unpacker.sv
// Bench for fifo_unpacker: a 16/2 LSB-first and a 32/4 MSB-first instance, each fed by
// a queue-based FIFO and checked against a per-word slice list built with plain arithmetic.
module tb_fifo_unpacker;

    logic clk;
    logic rst_n;
    logic flush;

    logic [15:0] a_rdata;
    logic        a_ne, a_pop, a_valid, a_ready, a_last, a_busy;
    logic [7:0]  a_data;

    logic [31:0] b_rdata;
    logic        b_ne, b_pop, b_valid, b_ready, b_last, b_busy;
    logic [7:0]  b_data;

    logic [15:0] a_fifo[$];
    logic [31:0] b_fifo[$];
    logic [7:0]  a_exp[$];
    logic [7:0]  b_exp[$];

    int total = 0;
    int bad   = 0;

    fifo_unpacker #(.IN_WIDTH(16), .RATIO(2), .MSB_FIRST(1'b0)) u_a (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_flush          (flush),
        .i_fifo_rdata     (a_rdata),
        .i_fifo_not_empty (a_ne),
        .o_fifo_pop       (a_pop),
        .o_data           (a_data),
        .o_valid          (a_valid),
        .i_ready          (a_ready),
        .o_last           (a_last),
        .o_busy           (a_busy)
    );

    fifo_unpacker #(.IN_WIDTH(32), .RATIO(4), .MSB_FIRST(1'b1)) u_b (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_flush          (flush),
        .i_fifo_rdata     (b_rdata),
        .i_fifo_not_empty (b_ne),
        .o_fifo_pop       (b_pop),
        .o_data           (b_data),
        .o_valid          (b_valid),
        .i_ready          (b_ready),
        .o_last           (b_last),
        .o_busy           (b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Slices of a word in emission order, as a list the consumer should see.
    task automatic expand(input logic [31:0] word, input int ratio, input bit msb,
                          output logic [7:0] sl[4]);
        for (int k = 0; k < 4; k++) sl[k] = 8'h00;
        for (int k = 0; k < ratio; k++) begin
            int pos;
            pos   = msb ? (ratio - 1 - k) : k;
            sl[k] = 8'((word >> (pos * 8)) & 32'hFF);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_a_valid"}, 32'(a_valid), 32'h0);
        check({tag, "_a_last"},  32'(a_last),  32'h0);
        check({tag, "_a_data"},  32'(a_data),  32'h0);
        check({tag, "_b_valid"}, 32'(b_valid), 32'h0);
        check({tag, "_b_last"},  32'(b_last),  32'h0);
        check({tag, "_b_data"},  32'(b_data),  32'h0);
    endtask

    // One clock: drive at negedge, check 1 ns later, advance the model after posedge.
    task automatic step(input bit ra, input bit rb, input bit fl);
        bit          a_acc, b_acc, a_epop, b_epop;
        logic [31:0] w;
        logic [7:0]  sl[4];
        @(negedge clk);
        a_ready = ra;
        b_ready = rb;
        flush   = fl;
        a_ne    = (a_fifo.size() != 0);
        b_ne    = (b_fifo.size() != 0);
        a_rdata = a_ne ? a_fifo[0] : 16'($urandom);
        b_rdata = b_ne ? b_fifo[0] : $urandom;
        #1;
        a_acc  = (a_exp.size() != 0) && ra;
        b_acc  = (b_exp.size() != 0) && rb;
        a_epop = !fl && a_ne && (a_exp.size() == 0 || (a_acc && a_exp.size() == 1));
        b_epop = !fl && b_ne && (b_exp.size() == 0 || (b_acc && b_exp.size() == 1));
        check("a_pop",   32'(a_pop),   32'(a_epop));
        check("a_valid", 32'(a_valid), 32'(a_exp.size() != 0));
        check("a_busy",  32'(a_busy),  32'(a_exp.size() != 0));
        check("a_last",  32'(a_last),  32'(a_exp.size() == 1));
        if (a_exp.size() != 0) check("a_data", 32'(a_data), 32'(a_exp[0]));
        check("b_pop",   32'(b_pop),   32'(b_epop));
        check("b_valid", 32'(b_valid), 32'(b_exp.size() != 0));
        check("b_busy",  32'(b_busy),  32'(b_exp.size() != 0));
        check("b_last",  32'(b_last),  32'(b_exp.size() == 1));
        if (b_exp.size() != 0) check("b_data", 32'(b_data), 32'(b_exp[0]));
        @(posedge clk);
        if (fl) begin
            a_exp.delete();
            b_exp.delete();
            a_fifo.delete();
            b_fifo.delete();
        end else begin
            if (a_acc) void'(a_exp.pop_front());
            if (b_acc) void'(b_exp.pop_front());
            if (a_epop) begin
                w = 32'(a_fifo.pop_front());
                expand(w, 2, 1'b0, sl);
                for (int k = 0; k < 2; k++) a_exp.push_back(sl[k]);
            end
            if (b_epop) begin
                w = b_fifo.pop_front();
                expand(w, 4, 1'b1, sl);
                for (int k = 0; k < 4; k++) b_exp.push_back(sl[k]);
            end
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        flush   = 1'b0;
        a_ready = 1'b0;
        b_ready = 1'b0;
        a_ne    = 1'b0;
        b_ne    = 1'b0;
        a_rdata = '0;
        b_rdata = '0;

        // Reset state, including no pop request toward an empty FIFO.
        #12;
        check_zero("reset");
        check("reset_a_pop", 32'(a_pop), 32'h0);
        check("reset_b_pop", 32'(b_pop), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single word, then idle.
        a_fifo.push_back(16'hA1B2);
        repeat (4) step(1'b1, 1'b1, 1'b0);

        // Three words back to back with no bubble.
        a_fifo.push_back(16'h1122);
        a_fifo.push_back(16'h3344);
        a_fifo.push_back(16'h5566);
        repeat (7) step(1'b1, 1'b1, 1'b0);

        // Backpressure for four cycles on the first slice.
        a_fifo.push_back(16'hA1B2);
        step(1'b1, 1'b1, 1'b0);
        repeat (4) step(1'b0, 1'b1, 1'b0);
        repeat (3) step(1'b1, 1'b1, 1'b0);

        // Flush after the first slice; the queued word is dropped with it.
        a_fifo.push_back(16'h1122);
        a_fifo.push_back(16'h3344);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        #1;
        check_zero("flush");
        a_fifo.push_back(16'h7788);
        repeat (4) step(1'b1, 1'b1, 1'b0);

        // Asynchronous reset pulse between clock edges while a word is held.
        a_fifo.push_back(16'hA1B2);
        step(1'b1, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check_zero("async_rst");
        a_exp.delete();
        b_exp.delete();
        #1 rst_n = 1'b1;
        a_fifo.push_back(16'h1122);
        repeat (4) step(1'b1, 1'b1, 1'b0);

        // MSB-first wide word on the 32/4 instance.
        b_fifo.push_back(32'hDEADBEEF);
        repeat (6) step(1'b1, 1'b1, 1'b0);

        // Randomized traffic, backpressure and occasional flushes on both instances.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) == 0 && a_fifo.size() < 6) a_fifo.push_back(16'($urandom));
            if ($urandom_range(0, 3) == 0 && b_fifo.size() < 6) b_fifo.push_back($urandom);
            step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 63) == 0);
        end

        // Drain with a bounded budget; anything left over means the DUT stalled.
        for (int i = 0; i < 60 && (a_exp.size() + b_exp.size() + a_fifo.size() + b_fifo.size()) != 0; i++)
            step(1'b1, 1'b1, 1'b0);
        check("drain_left", 32'(a_exp.size() + b_exp.size() + a_fifo.size() + b_fifo.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
